avalon_spi_bridge: RTL and testbench

AVALON_SPI_BRIDGE -- requirements
Module: avalon_spi_bridge

---
 rtl/avalon_spi_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_avalon_spi_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_spi_bridge.sv
// Avalon-MM slave that drives a simple SPI engine.
// The bridge starts one SPI word transfer per TXDATA write and collects
// the received words in a small RX FIFO. It provides status flags and a
// level interrupt.
module avalon_spi_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  // Avalon-MM slave
  input  logic              chip_select,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              wait_request,
  output logic              irq,
  // SPI core side
  output logic              go_transfer,
  output logic [DATA_W-1:0] data_write_to_spi,
  output logic              spi_cs,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] data_read_from_spi
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] REG_CONTROL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_STATUS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_TXDATA  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_RXDATA  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_RXLEVEL = ADDR_W'(4);

  localparam logic [1:0] MODE_WRITE = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t state;

  // Register fields
  logic       ctrl_cs;
  logic [1:0] ctrl_mode;
  logic       ctrl_irq_en;
  logic       ctrl_flush;
  logic       st_ovf;
  logic       st_done;

  // Transfer context
  logic [1:0]        xfer_mode;
  logic [DATA_W-1:0] rx_word;

  // RX FIFO
  logic [DATA_W-1:0] fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push_req;
  logic              pop_req;
  logic              push_eff;
  logic              pop_eff;
  logic              overflow;

  // Avalon access decode
  logic              wr_en;
  logic              rd_req;
  logic              rd_phase;
  logic              rd_first;
  logic              rd_done;
  logic              rd_pop_pending;
  logic              rd_clr_done;
  logic              hit_control;
  logic              hit_status;
  logic              hit_txdata;
  logic              hit_rxdata;
  logic              hit_rxlevel;
  logic              busy;
  logic              tx_accept;
  logic [DATA_W-1:0] rd_mux;

  assign wr_en       = chip_select & write;
  assign rd_req      = chip_select & read;
  assign rd_first    = rd_req & ~rd_phase;
  assign rd_done     = rd_req & rd_phase;
  assign wait_request = rd_first;

  assign hit_control = (address == REG_CONTROL);
  assign hit_status  = (address == REG_STATUS);
  assign hit_txdata  = (address == REG_TXDATA);
  assign hit_rxdata  = (address == REG_RXDATA);
  assign hit_rxlevel = (address == REG_RXLEVEL);

  assign busy       = (state != ST_IDLE);
  assign tx_accept  = wr_en & hit_txdata & ~busy;
  assign spi_cs     = ctrl_cs;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(RX_DEPTH));

  // A pop only happens when a completed RXDATA read saw data in its first cycle.
  assign push_req = (state == ST_CAPTURE) & (xfer_mode != MODE_WRITE);
  assign pop_req  = rd_done & rd_pop_pending;
  assign pop_eff  = pop_req & ~fifo_empty;
  assign push_eff = push_req & (~fifo_full | pop_eff);
  assign overflow = push_req & fifo_full & ~pop_eff;

  // Read-data multiplexer; undefined addresses and bits read as zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_mux unassigned (no latch).
    rd_mux = '0;
    if (hit_control) begin
      rd_mux[4:0] = {ctrl_flush, ctrl_irq_en, ctrl_mode, ctrl_cs};
    end else if (hit_status) begin
      rd_mux[4:0] = {st_done, st_ovf, fifo_full, fifo_empty, busy};
    end else if (hit_rxdata) begin
      if (!fifo_empty) rd_mux = fifo_mem[rd_ptr];
    end else if (hit_rxlevel) begin
      rd_mux = DATA_W'(fifo_count);
    end
  end

  // Two-cycle read: capture data and side-effect intent in cycle 1, complete in cycle 2.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    if (reset) begin
      read_data      <= '0;
      rd_phase       <= 1'b0;
      rd_pop_pending <= 1'b0;
      rd_clr_done    <= 1'b0;
    end else if (rd_first) begin
      read_data      <= rd_mux;
      rd_phase       <= 1'b1;
      rd_pop_pending <= hit_rxdata & ~fifo_empty;
      rd_clr_done    <= hit_status & st_done;
    end else begin
      rd_phase       <= 1'b0;
      rd_pop_pending <= 1'b0;
      rd_clr_done    <= 1'b0;
    end
  end

  // CONTROL register; FLUSH is a one-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_cs     <= 1'b0;
      ctrl_mode   <= 2'b00;
      ctrl_irq_en <= 1'b0;
      ctrl_flush  <= 1'b0;
    end else if (wr_en && hit_control) begin
      ctrl_cs     <= write_data[0];
      ctrl_mode   <= write_data[2:1];
      ctrl_irq_en <= write_data[3];
      ctrl_flush  <= write_data[4];
    end else begin
      ctrl_flush  <= 1'b0;
    end
  end

  // Sticky status flags. A new event wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_ovf  <= 1'b0;
      st_done <= 1'b0;
    end else begin
      if (ctrl_flush) begin
        st_ovf <= 1'b0;
      end else if (overflow) begin
        st_ovf <= 1'b1;
      end else if (wr_en && hit_status && write_data[3]) begin
        st_ovf <= 1'b0;
      end

      if (state == ST_CAPTURE) begin
        st_done <= 1'b1;
      end else if ((wr_en && hit_txdata) || (rd_done && rd_clr_done)) begin
        st_done <= 1'b0;
      end
    end
  end

  // Transfer FSM with registered go pulse and transmit word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      go_transfer       <= 1'b0;
      data_write_to_spi <= '0;
      xfer_mode         <= MODE_WRITE;
      rx_word           <= '0;
    end else begin
      go_transfer <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_accept) begin
            state             <= ST_START;
            go_transfer       <= 1'b1;
            data_write_to_spi <= (ctrl_mode == MODE_READ) ? '0 : write_data;
            xfer_mode         <= ctrl_mode;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (spi_done) begin
            rx_word <= data_read_from_spi;
            state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // RX FIFO pointers and level; flush overrides any concurrent push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (ctrl_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the level counter alone decides which entries are valid.
    if (push_eff && !ctrl_flush) fifo_mem[wr_ptr] <= rx_word;
  end

  // Registered level interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ctrl_irq_en & (st_done | ~fifo_empty | st_ovf);
    end
  end

endmodule

// File: tb/tb_avalon_spi_bridge.sv
// Directed self-checking bench for avalon_spi_bridge (DATA_W=32, RX_DEPTH=8).
module tb_avalon_spi_bridge;

  localparam logic [7:0] A_CONTROL = 8'd0;
  localparam logic [7:0] A_STATUS  = 8'd1;
  localparam logic [7:0] A_TXDATA  = 8'd2;
  localparam logic [7:0] A_RXDATA  = 8'd3;
  localparam logic [7:0] A_RXLEVEL = 8'd4;
  localparam logic [7:0] A_UNDEF   = 8'd7;

  logic        clk;
  logic        reset;
  logic        chip_select;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        wait_request;
  logic        irq;
  logic        go_transfer;
  logic [31:0] data_write_to_spi;
  logic        spi_cs;
  logic        spi_done;
  logic [31:0] data_read_from_spi;

  int n_checks = 0;
  int n_pass   = 0;
  int go_count = 0;

  avalon_spi_bridge #(.DATA_W(32), .ADDR_W(8), .RX_DEPTH(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .chip_select        (chip_select),
    .address            (address),
    .read               (read),
    .write              (write),
    .write_data         (write_data),
    .read_data          (read_data),
    .wait_request       (wait_request),
    .irq                (irq),
    .go_transfer        (go_transfer),
    .data_write_to_spi  (data_write_to_spi),
    .spi_cs             (spi_cs),
    .spi_done           (spi_done),
    .data_read_from_spi (data_read_from_spi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // go_transfer is stable for a whole cycle, so counting on the falling edge sees each pulse once.
  always @(negedge clk) if (go_transfer) go_count <= go_count + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [7:0] a, input logic [31:0] d);
    chip_select = 1'b1; write = 1'b1; address = a; write_data = d;
    @(posedge clk); #1;
    chip_select = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    chip_select = 1'b1; read = 1'b1; address = a;
    waits = 0;
    #1;
    while (wait_request && waits < 8) begin
      waits++;
      @(posedge clk); #1;
    end
    d = read_data;
    @(posedge clk); #1;
    chip_select = 1'b0; read = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    av_read(a, d, w);
    check(tag, d, exp);
  endtask

  task automatic spi_complete(input logic [31:0] d);
    data_read_from_spi = d; spi_done = 1'b1;
    @(posedge clk); #1;
    spi_done = 1'b0; data_read_from_spi = '0;
  endtask

  task automatic transfer(input logic [31:0] tx, input logic [31:0] rx);
    av_write(A_TXDATA, tx);
    idle(1);
    spi_complete(rx);
    idle(1);
  endtask

  initial begin
    logic [31:0] d;
    int w;
    int g0;

    reset = 1'b1; chip_select = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    write_data = '0; spi_done = 1'b0; data_read_from_spi = '0;
    idle(3);

    // Reset state
    check("rst_read_data", read_data, 32'h0);
    check("rst_wait_request", {31'b0, wait_request}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_go", {31'b0, go_transfer}, 32'h0);
    check("rst_dws", data_write_to_spi, 32'h0);
    check("rst_spi_cs", {31'b0, spi_cs}, 32'h0);
    reset = 1'b0;
    idle(1);
    read_check("rst_status", A_STATUS, 32'h2);
    read_check("rst_control", A_CONTROL, 32'h0);

    // Deselected accesses do nothing
    chip_select = 1'b0; read = 1'b1; address = A_STATUS; #1;
    check("nocs_wait_request", {31'b0, wait_request}, 32'h0);
    idle(1); read = 1'b0;
    chip_select = 1'b0; write = 1'b1; address = A_CONTROL; write_data = 32'h5;
    idle(1); write = 1'b0;
    read_check("nocs_write_ignored", A_CONTROL, 32'h0);

    // Undefined CONTROL bits, FLUSH self-clear
    av_write(A_CONTROL, 32'hFFFF_FFFF);
    read_check("ctrl_all_ones", A_CONTROL, 32'h1F);
    read_check("ctrl_flush_cleared", A_CONTROL, 32'h0F);
    av_write(A_CONTROL, 32'h0);
    av_write(A_UNDEF, 32'hFF);
    read_check("undef_write_ignored", A_CONTROL, 32'h0);

    // Duplex transfer basics
    av_write(A_CONTROL, 32'h5);
    check("spi_cs_set", {31'b0, spi_cs}, 32'h1);
    av_write(A_TXDATA, 32'hA5A5_A5A5);
    check("go_after_write", {31'b0, go_transfer}, 32'h1);
    check("dws_duplex", data_write_to_spi, 32'hA5A5_A5A5);
    idle(1);
    check("go_one_cycle", {31'b0, go_transfer}, 32'h0);
    read_check("status_busy", A_STATUS, 32'h3);
    check("dws_held", data_write_to_spi, 32'hA5A5_A5A5);
    spi_complete(32'hCAFE_F00D);
    idle(1);
    read_check("status_done", A_STATUS, 32'h10);
    read_check("level_one", A_RXLEVEL, 32'h1);
    av_read(A_RXDATA, d, w);
    check("rxdata_duplex", d, 32'hCAFE_F00D);
    check("rxdata_waits", w, 32'h1);
    read_check("status_after_pop", A_STATUS, 32'h2);

    // Read mode sends zeros
    av_write(A_CONTROL, 32'h3);
    av_write(A_TXDATA, 32'hDEAD_BEEF);
    check("dws_read_mode", data_write_to_spi, 32'h0);
    check("go_read_mode", {31'b0, go_transfer}, 32'h1);
    idle(1);
    spi_complete(32'h1234_5678);
    idle(1);
    read_check("level_read_mode", A_RXLEVEL, 32'h1);
    av_read(A_RXDATA, d, w);
    check("rxdata_read_mode", d, 32'h1234_5678);
    check("rxdata_read_waits", w, 32'h1);
    read_check("status_empty_done", A_STATUS, 32'h12);

    // Write mode does not push
    av_write(A_CONTROL, 32'h1);
    av_write(A_TXDATA, 32'h0BAD_F00D);
    check("dws_write_mode", data_write_to_spi, 32'h0BAD_F00D);
    idle(1);
    spi_complete(32'h66);
    idle(1);
    read_check("level_write_mode", A_RXLEVEL, 32'h0);
    read_check("status_write_mode", A_STATUS, 32'h12);

    // Overflow: nine transfers into eight entries
    av_write(A_CONTROL, 32'h5);
    for (int i = 0; i < 9; i++) transfer(32'(i), 32'h1000 + 32'(i));
    read_check("status_full_ovf", A_STATUS, 32'h1C);
    read_check("level_full", A_RXLEVEL, 32'h8);
    av_write(A_STATUS, 32'h8);
    read_check("status_ovf_cleared", A_STATUS, 32'h04);
    for (int i = 0; i < 8; i++) read_check($sformatf("drain_%0d", i), A_RXDATA, 32'h1000 + 32'(i));
    read_check("status_drained", A_STATUS, 32'h2);

    // Flush
    transfer(32'h1, 32'hAA);
    transfer(32'h2, 32'hBB);
    read_check("level_before_flush", A_RXLEVEL, 32'h2);
    av_write(A_CONTROL, 32'h15);
    idle(1);
    read_check("level_after_flush", A_RXLEVEL, 32'h0);
    read_check("ctrl_after_flush", A_CONTROL, 32'h5);
    read_check("status_after_flush", A_STATUS, 32'h12);

    // Interrupt
    av_write(A_CONTROL, 32'hD);
    idle(2);
    check("irq_quiet", {31'b0, irq}, 32'h0);
    av_write(A_TXDATA, 32'h1);
    idle(1);
    spi_complete(32'h55);
    idle(1);
    check("irq_registered_lag", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_set", {31'b0, irq}, 32'h1);
    read_check("irq_status", A_STATUS, 32'h10);
    check("irq_fifo_holds", {31'b0, irq}, 32'h1);
    read_check("irq_rxdata", A_RXDATA, 32'h55);
    idle(2);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    av_write(A_CONTROL, 32'h5);

    // Dropped TXDATA write while busy
    g0 = go_count;
    av_write(A_TXDATA, 32'h111);
    idle(2);
    av_write(A_TXDATA, 32'h222);
    check("dws_not_overwritten", data_write_to_spi, 32'h111);
    idle(2);
    check("single_go", go_count - g0, 32'h1);
    spi_complete(32'h77);
    idle(1);
    read_check("level_dropped", A_RXLEVEL, 32'h1);
    read_check("rxdata_dropped", A_RXDATA, 32'h77);
    read_check("status_dropped", A_STATUS, 32'h12);

    // Reset during WAIT, then stray spi_done
    av_write(A_TXDATA, 32'h333);
    idle(1);
    reset = 1'b1;
    idle(2);
    check("midrst_go", {31'b0, go_transfer}, 32'h0);
    check("midrst_dws", data_write_to_spi, 32'h0);
    check("midrst_spi_cs", {31'b0, spi_cs}, 32'h0);
    reset = 1'b0;
    idle(1);
    spi_complete(32'h99);
    idle(2);
    read_check("stray_done_status", A_STATUS, 32'h2);
    read_check("stray_done_level", A_RXLEVEL, 32'h0);

    // Empty RXDATA read and undefined address
    av_read(A_RXDATA, d, w);
    check("rxdata_empty", d, 32'h0);
    check("rxdata_empty_waits", w, 32'h1);
    read_check("level_after_empty_read", A_RXLEVEL, 32'h0);
    av_write(A_CONTROL, 32'h5);
    transfer(32'h4, 32'hABC);
    av_read(A_UNDEF, d, w);
    check("undef_read", d, 32'h0);
    check("undef_read_waits", w, 32'h1);
    read_check("level_after_undef_read", A_RXLEVEL, 32'h1);
    read_check("rxdata_last", A_RXDATA, 32'hABC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
